// File: rtl/led_mode_sequencer.sv
// ----------------------------------------------------------------------------
// led_mode_sequencer
//
// Drives the 8-LED bank from one of four sources. A debounced push-button
// picks the source:
//   PASS   - the LEDs mirror the switches
//   COUNT  - an 8-bit counter that advances once per prescaler tick
//   SHIFT  - a single lit bit that rotates once per tick; SW[0] picks the
//            direction
//   FREEZE - a copy of the switches taken at the moment FREEZE was entered
//
// Ports
//   clk    in   1  system clock; all logic runs on the rising edge
//   reset  in   1  synchronous, active-high; overrides all other activity
//   SW     in   8  switch inputs
//   BTN    in   1  raw mode-advance button; asynchronous and may bounce
//   LED    out  8  registered LED drive
//   MODE   out  2  current mode: 0=PASS 1=COUNT 2=SHIFT 3=FREEZE
//
// Mode FSM states
//   state       | meaning
//   ------------+--------------------------------------------------
//   MODE_PASS   | LED follows SW
//   MODE_COUNT  | LED shows the counter, which increments on each tick
//   MODE_SHIFT  | LED shows the rotating bit, which moves on each tick
//   MODE_FREEZE | LED shows the SW snapshot taken when this mode was entered
// ----------------------------------------------------------------------------
module led_mode_sequencer #(
    parameter int DEBOUNCE = 4,
    parameter int TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] SW,
    input  logic       BTN,
    output logic [7:0] LED,
    output logic [1:0] MODE
);

    // The debounce counter only ever holds 0..DEBOUNCE-1, because reaching
    // DEBOUNCE is detected one step early and the counter clears instead.
    localparam int DB_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);
    localparam int PS_W = $clog2(TICK_DIV);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_COUNT  = 2'd1,
        MODE_SHIFT  = 2'd2,
        MODE_FREEZE = 2'd3
    } mode_e;

    logic            sync1_q,       sync1_d;
    logic            sync2_q,       sync2_d;
    logic [DB_W-1:0] db_cnt_q,      db_cnt_d;
    logic            stable_q,      stable_d;
    logic            stable_prev_q, stable_prev_d;
    logic [PS_W-1:0] ps_q,          ps_d;
    mode_e           mode_q,        mode_d;
    logic [7:0]      count_q,       count_d;
    logic [7:0]      shift_q,       shift_d;
    logic [7:0]      freeze_q,      freeze_d;
    logic [7:0]      led_q,         led_d;

    logic press;
    logic tick;

    // ------------------------------------------------------------------------
    // Button synchroniser and debouncer
    // ------------------------------------------------------------------------
    always_comb begin
        sync1_d       = BTN;
        sync2_d       = sync1_q;
        stable_prev_d = stable_q;
        stable_d      = stable_q;
        db_cnt_d      = db_cnt_q;

        if (sync2_q == stable_q) begin
            // Input agrees with the accepted level; any partial run is discarded.
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            // This edge would bring the count to DEBOUNCE: accept the new level.
            stable_d = sync2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    // Only a rising edge of the debounced level is an event; release is silent.
    assign press = stable_q & ~stable_prev_q;

    // ------------------------------------------------------------------------
    // Prescaler: free-running, independent of mode
    // ------------------------------------------------------------------------
    assign tick = (ps_q == PS_LAST);

    always_comb begin
        ps_d = tick ? '0 : ps_q + PS_W'(1);
    end

    // ------------------------------------------------------------------------
    // Mode FSM and per-mode sources
    // ------------------------------------------------------------------------
    always_comb begin
        mode_d   = mode_q;
        count_d  = count_q;
        shift_d  = shift_q;
        freeze_d = freeze_q;

        if (press) begin
            // A press takes priority; a tick arriving on the same edge is dropped.
            unique case (mode_q)
                MODE_PASS: begin
                    mode_d  = MODE_COUNT;
                    count_d = 8'h00;
                end
                MODE_COUNT: begin
                    mode_d  = MODE_SHIFT;
                    shift_d = 8'h01;
                end
                MODE_SHIFT: begin
                    mode_d   = MODE_FREEZE;
                    freeze_d = SW;
                end
                MODE_FREEZE: begin
                    mode_d = MODE_PASS;
                end
                default: begin
                    mode_d = MODE_PASS;
                end
            endcase
        end else if (tick) begin
            unique case (mode_q)
                MODE_COUNT: begin
                    count_d = count_q + 8'd1;
                end
                MODE_SHIFT: begin
                    if (SW[0]) begin
                        shift_d = {shift_q[0], shift_q[7:1]};
                    end else begin
                        shift_d = {shift_q[6:0], shift_q[7]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The LED source follows the registered mode, so on a mode change the new
    // source's initial value appears one edge after MODE updates.
    always_comb begin
        led_d = 8'h00;
        unique case (mode_q)
            MODE_PASS:   led_d = SW;
            MODE_COUNT:  led_d = count_q;
            MODE_SHIFT:  led_d = shift_q;
            MODE_FREEZE: led_d = freeze_q;
            default:     led_d = SW;
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            db_cnt_q      <= '0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            ps_q          <= '0;
            mode_q        <= MODE_PASS;
            count_q       <= 8'h00;
            shift_q       <= 8'h01;
            freeze_q      <= 8'h00;
            led_q         <= 8'h00;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            db_cnt_q      <= db_cnt_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            ps_q          <= ps_d;
            mode_q        <= mode_d;
            count_q       <= count_d;
            shift_q       <= shift_d;
            freeze_q      <= freeze_d;
            led_q         <= led_d;
        end
    end

    assign LED  = led_q;
    assign MODE = mode_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
module tb_led_mode_sequencer;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] SW    = 8'h00;
    logic       BTN   = 1'b0;
    logic [7:0] LED;
    logic [1:0] MODE;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] e;
    logic [7:0] last;
    int         lat;
    int         guard;

    led_mode_sequencer #(.DEBOUNCE(4), .TICK_DIV(3)) dut (
        .clk  (clk),
        .reset(reset),
        .SW   (SW),
        .BTN  (BTN),
        .LED  (LED),
        .MODE (MODE)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired n_tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Lets any previous press release settle, then holds BTN until MODE moves.
    // lat_o is the number of edges from the first edge that sees BTN high
    // up to and including the edge where MODE changes.
    task automatic press_btn(output int lat_o);
        logic [1:0] m0;
        BTN = 1'b0;
        repeat (8) step();
        m0    = MODE;
        lat_o = 0;
        BTN   = 1'b1;
        while (MODE === m0 && lat_o < 20) begin
            step();
            lat_o++;
        end
        BTN = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        SW    = 8'hA5;
        BTN   = 1'b0;
        step();
        step();
        n_tests++;
        if (MODE !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_mode got=%0d exp=0", MODE);
        end
        exp_q.push_back(8'h00);
        e = exp_q.pop_front();
        n_tests++;
        if (LED !== e) begin
            n_fail++;
            $display("FAIL reset_led got=%h exp=%h", LED, e);
        end
        reset = 1'b0;
        exp_q.push_back(8'hA5);
        step();
        e = exp_q.pop_front();
        n_tests++;
        if (LED !== e) begin
            n_fail++;
            $display("FAIL reset_release_led got=%h exp=%h", LED, e);
        end
    endtask

    task automatic test_pass();
        logic [7:0] pats[4];
        logic [7:0] v;
        pats[0] = 8'h00;
        pats[1] = 8'hFF;
        pats[2] = 8'h5A;
        pats[3] = 8'h81;
        for (int i = 0; i < 10; i++) begin
            v  = (i < 4) ? pats[i] : 8'($urandom);
            SW = v;
            exp_q.push_back(v);
            step();
            e = exp_q.pop_front();
            n_tests++;
            if (LED !== e) begin
                n_fail++;
                $display("FAIL pass_led[%0d] got=%h exp=%h", i, LED, e);
            end
        end
    endtask

    task automatic test_glitch();
        BTN = 1'b1;
        repeat (3) step();
        BTN = 1'b0;
        repeat (10) step();
        n_tests++;
        if (MODE !== 2'd0) begin
            n_fail++;
            $display("FAIL glitch3_mode got=%0d exp=0", MODE);
        end
        repeat (6) begin
            BTN = 1'b1;
            step();
            BTN = 1'b0;
            step();
        end
        repeat (10) step();
        n_tests++;
        if (MODE !== 2'd0) begin
            n_fail++;
            $display("FAIL bounce_mode got=%0d exp=0", MODE);
        end
    endtask

    task automatic test_count();
        logic [7:0] v;
        SW = 8'h99;
        press_btn(lat);
        n_tests++;
        if (lat !== 7) begin
            n_fail++;
            $display("FAIL press_latency got=%0d exp=7", lat);
        end
        n_tests++;
        if (MODE !== 2'd1) begin
            n_fail++;
            $display("FAIL count_mode got=%0d exp=1", MODE);
        end
        exp_q.push_back(8'h00);
        step();
        e = exp_q.pop_front();
        n_tests++;
        if (LED !== e) begin
            n_fail++;
            $display("FAIL count_init got=%h exp=%h", LED, e);
        end
        v = 8'h00;
        for (int i = 0; i < 260; i++) begin
            v = v + 8'd1;
            exp_q.push_back(v);
        end
        last  = LED;
        guard = 0;
        while (exp_q.size() > 0 && guard < 800) begin
            step();
            guard++;
            if (LED !== last) begin
                e = exp_q.pop_front();
                n_tests++;
                if (LED !== e) begin
                    n_fail++;
                    $display("FAIL count_step got=%h exp=%h", LED, e);
                end
                last = LED;
            end
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL count_timeout got=%0d_pending exp=0_pending", exp_q.size());
            exp_q.delete();
        end
        n_tests++;
        if (LED !== 8'h04) begin
            n_fail++;
            $display("FAIL count_260 got=%h exp=04", LED);
        end
    endtask

    task automatic test_shift();
        logic [7:0] v;
        SW = 8'h00;
        press_btn(lat);
        n_tests++;
        if (MODE !== 2'd2) begin
            n_fail++;
            $display("FAIL shift_mode got=%0d exp=2", MODE);
        end
        exp_q.push_back(8'h01);
        step();
        e = exp_q.pop_front();
        n_tests++;
        if (LED !== e) begin
            n_fail++;
            $display("FAIL shift_init got=%h exp=%h", LED, e);
        end
        v = 8'h01;
        for (int i = 0; i < 8; i++) begin
            v = {v[6:0], v[7]};
            exp_q.push_back(v);
        end
        last  = LED;
        guard = 0;
        while (exp_q.size() > 0 && guard < 40) begin
            step();
            guard++;
            if (LED !== last) begin
                e = exp_q.pop_front();
                n_tests++;
                if (LED !== e) begin
                    n_fail++;
                    $display("FAIL shift_left got=%h exp=%h", LED, e);
                end
                last = LED;
            end
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL shift_left_timeout got=%0d_pending exp=0_pending", exp_q.size());
            exp_q.delete();
        end
        SW = 8'h01;
        exp_q.push_back(8'h80);
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            step();
            guard++;
            if (LED !== last) begin
                e = exp_q.pop_front();
                n_tests++;
                if (LED !== e) begin
                    n_fail++;
                    $display("FAIL shift_right got=%h exp=%h", LED, e);
                end
                last = LED;
            end
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL shift_right_timeout got=%0d_pending exp=0_pending", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_freeze();
        SW = 8'h3C;
        press_btn(lat);
        n_tests++;
        if (MODE !== 2'd3) begin
            n_fail++;
            $display("FAIL freeze_mode got=%0d exp=3", MODE);
        end
        exp_q.push_back(8'h3C);
        step();
        e = exp_q.pop_front();
        n_tests++;
        if (LED !== e) begin
            n_fail++;
            $display("FAIL freeze_init got=%h exp=%h", LED, e);
        end
        SW = 8'hFF;
        exp_q.push_back(8'h3C);
        repeat (12) step();
        e = exp_q.pop_front();
        n_tests++;
        if (LED !== e) begin
            n_fail++;
            $display("FAIL freeze_hold got=%h exp=%h", LED, e);
        end
        press_btn(lat);
        n_tests++;
        if (MODE !== 2'd0) begin
            n_fail++;
            $display("FAIL freeze_to_pass_mode got=%0d exp=0", MODE);
        end
        exp_q.push_back(8'hFF);
        step();
        e = exp_q.pop_front();
        n_tests++;
        if (LED !== e) begin
            n_fail++;
            $display("FAIL freeze_to_pass_led got=%h exp=%h", LED, e);
        end
    endtask

    task automatic test_reset_mid();
        press_btn(lat);
        n_tests++;
        if (MODE !== 2'd1) begin
            n_fail++;
            $display("FAIL reset_mid_enter got=%0d exp=1", MODE);
        end
        guard = 0;
        while (LED !== 8'h07 && guard < 40) begin
            step();
            guard++;
        end
        n_tests++;
        if (LED !== 8'h07) begin
            n_fail++;
            $display("FAIL reset_mid_reach7 got=%h exp=07", LED);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_tests++;
        if (MODE !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_mid_mode got=%0d exp=0", MODE);
        end
        exp_q.push_back(8'h00);
        e = exp_q.pop_front();
        n_tests++;
        if (LED !== e) begin
            n_fail++;
            $display("FAIL reset_mid_led got=%h exp=%h", LED, e);
        end
        SW = 8'h5A;
        exp_q.push_back(8'h5A);
        step();
        e = exp_q.pop_front();
        n_tests++;
        if (LED !== e) begin
            n_fail++;
            $display("FAIL reset_mid_follow1 got=%h exp=%h", LED, e);
        end
        SW = 8'hC3;
        exp_q.push_back(8'hC3);
        step();
        e = exp_q.pop_front();
        n_tests++;
        if (LED !== e) begin
            n_fail++;
            $display("FAIL reset_mid_follow2 got=%h exp=%h", LED, e);
        end
    endtask

    // A pulse of exactly DEBOUNCE synchronised cycles is the shortest accepted.
    task automatic test_pulse_boundary();
        BTN = 1'b0;
        repeat (8) step();
        BTN = 1'b1;
        repeat (4) step();
        BTN = 1'b0;
        guard = 0;
        while (MODE === 2'd0 && guard < 12) begin
            step();
            guard++;
        end
        n_tests++;
        if (MODE !== 2'd1) begin
            n_fail++;
            $display("FAIL pulse4_mode got=%0d exp=1", MODE);
        end
        n_tests++;
        if (guard !== 3) begin
            n_fail++;
            $display("FAIL pulse4_latency got=%0d exp=3", guard);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_glitch();
        test_count();
        test_shift();
        test_freeze();
        test_reset_mid();
        test_pulse_boundary();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
